debug_capture_sequencer: RTL and testbench

//  Sequences the 40-bit serial debug frame receiver: issues one-cycle data_start pulses,

---
 rtl/debug_capture_sequencer_if.sv | 52 +++++
 rtl/debug_capture_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_debug_capture_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/debug_capture_sequencer_if.sv
// ---------------------------------------------------------------------------
// debug_capture_sequencer_if
// Groups the control, receiver and frame-output signals of the debug capture
// sequencer. The sequencer takes the slave view. Debug control logic and the
// receiver/consumer side (or a testbench) take the master view.
//
// Signals (direction as seen by the sequencer):
//   arm           in   pulse: start a capture
//   continuous    in   level: re-arm automatically after each frame
//   stop          in   pulse: abort capture / end continuous mode
//   err_clear     in   pulse: clear sticky error flags
//   rx_data_start out  one-cycle start pulse to the serial receiver
//   rx_data       in   receiver frame register
//   rx_valid      in   receiver frame-done flag
//   frame_data    out  FIFO head
//   frame_valid   out  FIFO not empty
//   frame_ready   in   consumer accepts head
//   busy          out  sequencer not idle
//   overflow      out  sticky: frame dropped on full FIFO
//   timeout_err   out  sticky: receiver did not finish in time
//   frame_count   out  frames written to the FIFO (wrapping)
// ---------------------------------------------------------------------------
interface debug_capture_sequencer_if #(
  parameter int DATA_W = 40
);
  logic              arm;
  logic              continuous;
  logic              stop;
  logic              err_clear;
  logic              rx_data_start;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic [DATA_W-1:0] frame_data;
  logic              frame_valid;
  logic              frame_ready;
  logic              busy;
  logic              overflow;
  logic              timeout_err;
  logic [15:0]       frame_count;

  modport slave (
    input  arm, continuous, stop, err_clear, rx_data, rx_valid, frame_ready,
    output rx_data_start, frame_data, frame_valid, busy, overflow, timeout_err,
           frame_count
  );

  modport master (
    output arm, continuous, stop, err_clear, rx_data, rx_valid, frame_ready,
    input  rx_data_start, frame_data, frame_valid, busy, overflow, timeout_err,
           frame_count
  );
endinterface

// File: rtl/debug_capture_sequencer.sv
// ---------------------------------------------------------------------------
// debug_capture_sequencer
// Drives the 40-bit serial debug frame receiver. It issues one-cycle start
// pulses and waits, with a timeout, for each frame to complete. Finished
// frames are buffered in a small FIFO that the consumer drains through a
// valid/ready handshake. Single-shot and continuous capture, abort and
// sticky error flags are supported.
//
// Ports:
//   debug_clk  in  clock, all logic on posedge
//   reset      in  asynchronous, active-high reset
//   bus        debug_capture_sequencer_if.slave (control, receiver, frame out)
//
// Parameters:
//   DATA_W          frame width (40 for the debug receiver)
//   DEPTH           FIFO depth in frames, power of two, >= 2
//   TIMEOUT_CYCLES  max cycles spent in WAIT/DRAIN, >= 42
//   GAP_CYCLES      idle cycles required after rx_valid falls, >= 2
// ---------------------------------------------------------------------------
module debug_capture_sequencer #(
  parameter int DATA_W         = 40,
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int GAP_CYCLES     = 2
) (
  input  logic                    debug_clk,
  input  logic                    reset,
  debug_capture_sequencer_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_GAP,
    S_DRAIN
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic              rx_valid_q;
  logic              rx_rise;
  logic [TW-1:0]     timer;
  logic              timer_done;
  logic [GW-1:0]     gap_cnt;
  logic              gap_done;
  logic              stop_latched;
  logic              rx_data_start_q;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push_req;
  logic              do_push;
  logic              do_pop;

  logic              timeout_evt;
  logic              overflow_evt;
  logic              overflow_q;
  logic              timeout_err_q;
  logic [15:0]       frame_count_q;

  // Only the rising edge of rx_valid marks a completed frame; the flag may
  // stay high for a second cycle.
  assign rx_rise    = bus.rx_valid & ~rx_valid_q;
  assign timer_done = (timer == TIMER_LAST);
  // gap_cnt counts consecutive low cycles of rx_valid inside GAP, the
  // current cycle included.
  assign gap_done   = ~bus.rx_valid & (gap_cnt == GAP_LAST);

  assign fifo_empty   = (wr_ptr == rd_ptr);
  assign fifo_full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop       = ~fifo_empty & bus.frame_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push      = push_req & (~fifo_full | do_pop);
  assign overflow_evt = push_req & fifo_full & ~do_pop;

  always_comb begin
    state_nxt   = state;
    push_req    = 1'b0;
    timeout_evt = 1'b0;
    case (state)
      S_IDLE: begin
        // A receiver left running by a reset must finish before re-arming.
        if (bus.arm && !bus.stop && !bus.rx_valid) state_nxt = S_START;
      end
      S_START: begin
        state_nxt = bus.stop ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        if (rx_rise) begin
          push_req  = 1'b1;
          state_nxt = S_GAP;
        end else if (bus.stop) begin
          state_nxt = S_DRAIN;
        end else if (timer_done) begin
          timeout_evt = 1'b1;
          state_nxt   = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_done) begin
          state_nxt = (bus.continuous && !stop_latched && !bus.stop) ?
                      S_START : S_IDLE;
        end
      end
      S_DRAIN: begin
        // The receiver cannot be aborted: let its frame land and discard it.
        if (rx_rise) begin
          state_nxt = S_GAP;
        end else if (timer_done) begin
          timeout_evt = 1'b1;
          state_nxt   = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge debug_clk or posedge reset) begin
    if (reset) begin
      state           <= S_IDLE;
      rx_valid_q      <= 1'b0;
      timer           <= '0;
      gap_cnt         <= '0;
      stop_latched    <= 1'b0;
      rx_data_start_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      rx_valid_q <= bus.rx_valid;
      // Registered from the state so the pulse lands one cycle after START
      // is entered, i.e. two edges after arm is sampled.
      rx_data_start_q <= (state == S_START);

      if (state == S_START) begin
        timer <= '0;
      end else if (state == S_WAIT || state == S_DRAIN) begin
        timer <= timer + 1'b1;
      end

      if (state != S_GAP || bus.rx_valid) begin
        gap_cnt <= '0;
      end else if (gap_cnt != GAP_LAST) begin
        gap_cnt <= gap_cnt + 1'b1;
      end

      if (state_nxt == S_IDLE) begin
        stop_latched <= 1'b0;
      end else if (state != S_IDLE && bus.stop) begin
        stop_latched <= 1'b1;
      end
    end
  end

  always_ff @(posedge debug_clk or posedge reset) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      overflow_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      frame_count_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr        <= wr_ptr + 1'b1;
        frame_count_q <= frame_count_q + 16'd1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;

      // A set event wins over a clear in the same cycle.
      if (overflow_evt)       overflow_q <= 1'b1;
      else if (bus.err_clear) overflow_q <= 1'b0;

      if (timeout_evt)        timeout_err_q <= 1'b1;
      else if (bus.err_clear) timeout_err_q <= 1'b0;
    end
  end

  // Frame storage carries data only and is left out of reset.
  always_ff @(posedge debug_clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= bus.rx_data;
  end

  assign bus.rx_data_start = rx_data_start_q;
  // Gated so the head reads zero while the FIFO is empty, including after reset.
  assign bus.frame_data    = fifo_empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign bus.frame_valid   = ~fifo_empty;
  assign bus.busy          = (state != S_IDLE);
  assign bus.overflow      = overflow_q;
  assign bus.timeout_err   = timeout_err_q;
  assign bus.frame_count   = frame_count_q;

endmodule

// File: tb/tb_debug_capture_sequencer.sv
// ---------------------------------------------------------------------------
// tb_debug_capture_sequencer
// Bench for debug_capture_sequencer. A behavioural receiver answers each
// rx_data_start with a two-cycle rx_valid 41 cycles later. Frames expected to
// be stored are queued and compared as the consumer pops them.
// ---------------------------------------------------------------------------
module tb_debug_capture_sequencer;

  localparam int DEPTH  = 4;
  localparam int RX_LAT = 41;

  logic debug_clk = 1'b0;
  logic reset;

  always #5 debug_clk = ~debug_clk;

  debug_capture_sequencer_if #(.DATA_W(40)) bus ();

  debug_capture_sequencer #(
    .DATA_W(40),
    .DEPTH(DEPTH),
    .TIMEOUT_CYCLES(64),
    .GAP_CYCLES(2)
  ) dut (
    .debug_clk(debug_clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    logic [39:0] data;
    logic [15:0] exp_count;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [39:0] ref_q [$];
  logic [39:0] rx_base;
  bit          rx_resp_en;
  bit          store_en;
  int          rx_cnt = -1;
  int          rx_seq = 0;
  int          pulse_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge debug_clk);
    #1;
  endtask

  task automatic pulse_arm();
    bus.arm = 1'b1;
    cyc(1);
    bus.arm = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge debug_clk);
      n++;
    end while (bus.busy && n < budget);
    checks++;
    if (bus.busy) begin
      errors++;
      $display("FAIL %s: busy still 1 after %0d cycles, expected 0", name, n);
    end
  endtask

  task automatic pop_one();
    cyc(1);
    bus.frame_ready = 1'b1;
    cyc(1);
    bus.frame_ready = 1'b0;
  endtask

  // Receiver model and output scoreboard share one process so the order of
  // queue pushes and pops within a cycle is fixed.
  initial begin
    logic [39:0] exp_d;
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;
    forever begin
      @(negedge debug_clk);
      if (bus.rx_data_start) pulse_cnt++;
      if (bus.frame_valid && bus.frame_ready) begin
        if (ref_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_unexpected: got %0h, expected no frame", bus.frame_data);
        end else begin
          exp_d = ref_q.pop_front();
          chk("pop_data", 64'(bus.frame_data), 64'(exp_d));
        end
      end
      if (rx_cnt >= 0) begin
        rx_cnt++;
        if (rx_cnt == RX_LAT) begin
          bus.rx_valid = 1'b1;
          bus.rx_data  = rx_base;
          if (store_en && ref_q.size() < DEPTH) ref_q.push_back(rx_base);
          rx_base = rx_base + 40'd1;
          rx_seq++;
        end else if (rx_cnt == RX_LAT + 2) begin
          bus.rx_valid = 1'b0;
          rx_cnt = -1;
        end
      end else if (bus.rx_data_start && rx_resp_en) begin
        rx_cnt = 0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t vec [3];
    int   p0, s0, n;

    vec[0] = '{data: 40'hA5_1234_5678, exp_count: 16'd1};
    vec[1] = '{data: 40'hFF_FFFF_FFFF, exp_count: 16'd2};
    vec[2] = '{data: 40'h00_0000_0001, exp_count: 16'd3};

    reset            = 1'b1;
    bus.arm          = 1'b0;
    bus.continuous   = 1'b0;
    bus.stop         = 1'b0;
    bus.err_clear    = 1'b0;
    bus.frame_ready  = 1'b0;
    rx_base          = '0;
    rx_resp_en       = 1'b1;
    store_en         = 1'b1;

    cyc(3);
    @(negedge debug_clk);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_start", bus.rx_data_start, 1'b0);
    chk("rst_valid", bus.frame_valid, 1'b0);
    chk("rst_data", bus.frame_data, 40'h0);
    chk("rst_ovf", bus.overflow, 1'b0);
    chk("rst_tmo", bus.timeout_err, 1'b0);
    chk("rst_count", bus.frame_count, 16'd0);
    cyc(1);
    reset = 1'b0;

    // Single-shot captures
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      rx_base = vec[i].data;
      p0 = pulse_cnt;
      bus.arm = 1'b1;
      cyc(1);
      bus.arm = 1'b0;
      @(negedge debug_clk);
      chk("start_early", bus.rx_data_start, 1'b0);
      chk("busy_rise", bus.busy, 1'b1);
      @(negedge debug_clk);
      chk("start_pulse", bus.rx_data_start, 1'b1);
      @(negedge debug_clk);
      chk("start_end", bus.rx_data_start, 1'b0);
      wait_idle("cap_idle", 200);
      chk("cap_count", bus.frame_count, vec[i].exp_count);
      chk("cap_valid", bus.frame_valid, 1'b1);
      chk("cap_pulses", pulse_cnt - p0, 1);
      pop_one();
      @(negedge debug_clk);
      chk("cap_empty", bus.frame_valid, 1'b0);
    end

    // Continuous mode overflowing the FIFO
    cyc(1);
    rx_base = 40'hC0_0000_0000;
    p0 = pulse_cnt;
    s0 = rx_seq;
    bus.continuous = 1'b1;
    pulse_arm();
    n = 0;
    while (rx_seq - s0 < 6 && n < 2000) begin
      @(negedge debug_clk);
      n++;
    end
    bus.continuous = 1'b0;
    chk("cont_frames", rx_seq - s0, 6);
    wait_idle("cont_idle", 200);
    chk("cont_ovf", bus.overflow, 1'b1);
    chk("cont_count", bus.frame_count, 16'd7);
    chk("cont_pulses", pulse_cnt - p0, 6);
    chk("cont_valid", bus.frame_valid, 1'b1);
    cyc(1);
    bus.frame_ready = 1'b1;
    n = 0;
    while (ref_q.size() > 0 && n < 20) begin
      @(negedge debug_clk);
      n++;
    end
    cyc(1);
    bus.frame_ready = 1'b0;
    @(negedge debug_clk);
    chk("cont_drained", bus.frame_valid, 1'b0);
    chk("cont_left", ref_q.size(), 0);
    cyc(1);
    bus.err_clear = 1'b1;
    cyc(1);
    bus.err_clear = 1'b0;
    @(negedge debug_clk);
    chk("ovf_clear", bus.overflow, 1'b0);

    // Timeout with a silent receiver
    cyc(1);
    rx_resp_en = 1'b0;
    pulse_arm();
    n = 0;
    do begin
      @(negedge debug_clk);
      n++;
    end while (!bus.timeout_err && n < 200);
    chk("tmo_latency", n, 66);
    chk("tmo_flag", bus.timeout_err, 1'b1);
    wait_idle("tmo_idle", 50);
    chk("tmo_empty", bus.frame_valid, 1'b0);
    chk("tmo_count", bus.frame_count, 16'd7);
    cyc(1);
    bus.err_clear = 1'b1;
    cyc(1);
    bus.err_clear = 1'b0;
    @(negedge debug_clk);
    chk("tmo_clear", bus.timeout_err, 1'b0);
    rx_resp_en = 1'b1;

    // Stop during WAIT: the frame is drained and discarded
    cyc(1);
    store_en = 1'b0;
    p0 = pulse_cnt;
    s0 = rx_seq;
    pulse_arm();
    cyc(11);
    bus.stop = 1'b1;
    cyc(1);
    bus.stop = 1'b0;
    wait_idle("drain_idle", 200);
    chk("drain_rx_seen", rx_seq - s0, 1);
    chk("drain_count", bus.frame_count, 16'd7);
    chk("drain_empty", bus.frame_valid, 1'b0);
    cyc(10);
    @(negedge debug_clk);
    chk("drain_pulses", pulse_cnt - p0, 1);
    chk("drain_busy", bus.busy, 1'b0);
    store_en = 1'b1;

    // Arm and stop together in IDLE
    cyc(1);
    p0 = pulse_cnt;
    bus.arm  = 1'b1;
    bus.stop = 1'b1;
    cyc(1);
    bus.arm  = 1'b0;
    bus.stop = 1'b0;
    @(negedge debug_clk);
    chk("armstop_busy", bus.busy, 1'b0);
    cyc(3);
    @(negedge debug_clk);
    chk("armstop_busy2", bus.busy, 1'b0);
    chk("armstop_pulses", pulse_cnt - p0, 0);

    // Reset in the middle of WAIT; the receiver keeps running
    cyc(1);
    store_en = 1'b0;
    s0 = rx_seq;
    pulse_arm();
    cyc(20);
    @(negedge debug_clk);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", bus.busy, 1'b0);
    chk("mid_rst_start", bus.rx_data_start, 1'b0);
    chk("mid_rst_count", bus.frame_count, 16'd0);
    chk("mid_rst_valid", bus.frame_valid, 1'b0);
    chk("mid_rst_flags", {bus.overflow, bus.timeout_err}, 2'b00);
    cyc(2);
    reset = 1'b0;
    n = 0;
    while ((rx_seq == s0 || bus.rx_valid) && n < 200) begin
      @(negedge debug_clk);
      n++;
    end
    chk("late_rx_seen", rx_seq - s0, 1);
    chk("late_busy", bus.busy, 1'b0);
    chk("late_valid", bus.frame_valid, 1'b0);
    chk("late_count", bus.frame_count, 16'd0);
    store_en = 1'b1;
    cyc(1);
    rx_base = 40'h3C_0F0F_F0F0;
    pulse_arm();
    wait_idle("post_rst_idle", 200);
    chk("post_rst_count", bus.frame_count, 16'd1);
    chk("post_rst_valid", bus.frame_valid, 1'b1);
    pop_one();
    @(negedge debug_clk);
    chk("post_rst_empty", bus.frame_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
